i2c_controller: RTL and testbench

Single-master I2C engine issuing one-byte write or one-byte read transactions to a 7-bit-addressed target. It sits between a device-level controller (for example the FT6206 touch controller block) and the open-drain SCL/SDA pins. It accepts one command per valid/ready handshake and returns read bytes on a valid/ready output port.

---
 rtl/i2c_controller_pkg.sv | 20 ++
 rtl/i2c_phase_timer.sv | 32 +++
 rtl/i2c_controller.sv | 199 +++++++++++++++++++
 tb/tb_i2c_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_controller_pkg.sv
// i2c_controller shared types: transaction kind and FSM state.
// Build option: I2C_CONTROLLER_ACK_CHECK_EN aborts on a NACKed ACK bit.
package i2c_types;

  typedef enum logic {
    WRITE_8BIT_REGISTER = 1'b0,
    READ_8BIT           = 1'b1
  } i2c_transaction_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ACK1,
    S_DATA,
    S_ACK2,
    S_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: half-period down-counter for the I2C engine.
// Ticks on the last clk of every half period; restart reloads it.
module i2c_phase_timer #(
  parameter int unsigned COUNT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] RELOAD = W'(COUNT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload on restart or at the end of a half period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || cnt_q == '0) cnt_d = RELOAD;
    else                          cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-master one-byte I2C write/read engine.
// Build option: I2C_CONTROLLER_ACK_CHECK_EN aborts on a NACKed ACK bit.
import i2c_types::*;

module i2c_controller #(
  parameter int unsigned CLK_HZ        = 12_000_000,
  parameter int unsigned I2C_CLK_HZ    = 400_000,
  parameter int unsigned DIVIDER_COUNT = CLK_HZ / I2C_CLK_HZ / 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             scl,
  inout  wire              sda,
  input  i2c_transaction_t mode,
  output logic             i_ready,
  input  logic             i_valid,
  input  logic [6:0]       i_addr,
  input  logic [7:0]       i_data,
  input  logic             o_ready,
  output logic             o_valid,
  output logic [7:0]       o_data
);

  i2c_state_t  state_q, state_d;
  logic        half_q, half_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  stop_q, stop_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rx_q, rx_d;
  logic        rd_q, rd_d;
  logic        abort_q, abort_d;
  logic        o_valid_q, o_valid_d;
  logic [7:0]  o_data_q, o_data_d;
  logic        scl_q, scl_d;
  logic        sda_low_q, sda_low_d;
  logic        tick;
  logic        accept;
  logic        sda_in;

  assign sda_in = sda;
  assign accept = i_valid & i_ready;

  i2c_phase_timer #(
    .COUNT(DIVIDER_COUNT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .restart_i(state_q == S_IDLE),
    .tick_o   (tick)
  );

  // Sequencer: walks START, address, ACK, data, ACK, STOP.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    tx_d      = tx_q;
    data_d    = data_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    abort_d   = abort_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (o_ready) o_valid_d = 1'b0;
        if (accept) begin
          o_valid_d = 1'b0;
          rd_d      = (mode == READ_8BIT);
          tx_d      = {i_addr, mode == READ_8BIT};
          data_d    = i_data;
          abort_d   = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_ADDR;
          half_d  = 1'b0;
          bit_d   = 3'd0;
        end
      end
      S_ADDR, S_DATA: begin
        if (tick && !half_q) half_d = 1'b1;
        if (tick && half_q) begin
          half_d = 1'b0;
          tx_d   = {tx_q[6:0], 1'b0};
          bit_d  = bit_q + 3'd1;
          if (state_q == S_DATA) rx_d = {rx_q[6:0], sda_in};
          if (bit_q == 3'd7)
            state_d = (state_q == S_ADDR) ? S_ACK1 : S_ACK2;
        end
      end
      S_ACK1: begin
        if (tick && !half_q) half_d = 1'b1;
        if (tick && half_q) begin
          half_d  = 1'b0;
          state_d = S_DATA;
          tx_d    = data_q;
          bit_d   = 3'd0;
`ifdef I2C_CONTROLLER_ACK_CHECK_EN
          if (sda_in) begin
            abort_d = 1'b1;
            state_d = S_STOP;
          end
`endif
        end
      end
      S_ACK2: begin
        if (tick && !half_q) half_d = 1'b1;
        if (tick && half_q) begin
          half_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_q == 2'd2) begin
            stop_d  = 2'd0;
            state_d = S_IDLE;
            if (rd_q) begin
              o_valid_d = 1'b1;
              o_data_d  = abort_q ? 8'hFF : rx_q;
            end
          end else begin
            stop_d = stop_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin levels for the state being entered, registered glitch-free.
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    unique case (state_d)
      S_IDLE:  ;
      S_START: sda_low_d = 1'b1;
      S_ADDR: begin
        scl_d     = half_d;
        sda_low_d = ~tx_d[7];
      end
      S_DATA: begin
        scl_d     = half_d;
        sda_low_d = ~rd_d & ~tx_d[7];
      end
      S_ACK1, S_ACK2: scl_d = half_d;
      S_STOP: begin
        scl_d     = (stop_d != 2'd0);
        sda_low_d = (stop_d != 2'd2);
      end
      default: ;
    endcase
  end

  // State and pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      half_q    <= 1'b0;
      bit_q     <= 3'd0;
      stop_q    <= 2'd0;
      tx_q      <= 8'h00;
      data_q    <= 8'h00;
      rx_q      <= 8'h00;
      rd_q      <= 1'b0;
      abort_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= 8'h00;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      data_q    <= data_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      abort_q   <= abort_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign sda     = sda_low_q ? 1'b0 : 1'bz;
  assign scl     = scl_q;
  assign i_ready = (state_q == S_IDLE) & ~rst;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: bus-level target model and transaction checker
// for i2c_controller (handles either ACK-check build option).
module tb_i2c_controller;
  import i2c_types::*;

  localparam int H = 15;
  localparam logic [6:0] TGT = 7'h38;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire sda;
  pullup (sda);
  logic tgt_low = 1'b0;
  assign sda = tgt_low ? 1'b0 : 1'bz;

  logic             scl;
  i2c_transaction_t mode = WRITE_8BIT_REGISTER;
  logic             i_ready;
  logic             i_valid = 1'b0;
  logic [6:0]       i_addr = 7'h00;
  logic [7:0]       i_data = 8'h00;
  logic             o_ready = 1'b0;
  logic             o_valid;
  logic [7:0]       o_data;

  i2c_controller dut (
    .clk    (clk),
    .rst    (rst),
    .scl    (scl),
    .sda    (sda),
    .mode   (mode),
    .i_ready(i_ready),
    .i_valid(i_valid),
    .i_addr (i_addr),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data)
  );

  int ntests = 0;
  int nfail  = 0;

  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       s_v;
  logic       tgt_sel = 1'b0;
  logic       tgt_rw = 1'b0;
  logic [7:0] tgt_data = 8'h00;
  logic [7:0] mon_ab;
  bit         bits[$];
  int         start_cnt = 0;
  int         stop_cnt = 0;

  function automatic logic sda_level();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  // Bus monitor plus a simple one-register target at address TGT.
  always @(negedge clk) begin
    int n;
    s_v = sda_level();
    if (scl === 1'b1 && prev_scl && prev_sda && !s_v) begin
      start_cnt++;
      bits.delete();
    end else if (scl === 1'b1 && prev_scl && !prev_sda && s_v) begin
      stop_cnt++;
    end
    if (scl === 1'b1 && !prev_scl) bits.push_back(s_v);
    if (scl === 1'b0 && prev_scl) begin
      n = bits.size();
      if (n == 8) begin
        mon_ab = 8'h00;
        for (int i = 0; i < 8; i++) mon_ab = {mon_ab[6:0], bits[i]};
        tgt_sel = (mon_ab[7:1] == TGT);
        tgt_rw  = mon_ab[0];
        tgt_low = tgt_sel;
      end else if (n >= 9 && n <= 16) begin
        tgt_low = (tgt_sel && tgt_rw) ? ~tgt_data[16-n] : 1'b0;
      end else if (n == 17) begin
        tgt_low = tgt_sel && !tgt_rw;
      end else begin
        tgt_low = 1'b0;
      end
    end
    prev_scl = scl;
    prev_sda = s_v;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      b = {b[6:0], (base + i < bits.size()) ? bits[base+i] : 1'b0};
    return b;
  endfunction

  task automatic run_txn(input logic rd, input logic [6:0] a,
                         input logic [7:0] d, input logic [7:0] td);
    int         cnt;
    logic       ov_seen;
    logic       acked;
    logic       abort;
    int         exp_cyc;
    logic [7:0] exp_rd;
    tgt_data  = td;
    tgt_low   = 1'b0;
    start_cnt = 0;
    stop_cnt  = 0;
    @(negedge clk);
    mode    = rd ? READ_8BIT : WRITE_8BIT_REGISTER;
    i_addr  = a;
    i_data  = d;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    cnt     = 0;
    ov_seen = 1'b0;
    while (cnt < 2000) begin
      @(negedge clk);
      if (i_ready) break;
      cnt++;
      if (o_valid) ov_seen = 1'b1;
    end
    acked = (a == TGT);
`ifdef I2C_CONTROLLER_ACK_CHECK_EN
    abort = !acked;
`else
    abort = 1'b0;
`endif
    exp_cyc = abort ? (H + 9 * 2 * H + 3 * H) : 40 * H;
    exp_rd  = acked ? td : 8'hFF;
    check("busy_cycles", cnt, exp_cyc);
    check("start_seen", start_cnt, 1);
    check("stop_seen", stop_cnt, 1);
    check("addr_byte", get_byte(0), {a, rd});
    check("ack1", (bits.size() > 8) ? bits[8] : 1'bx, acked ? 1'b0 : 1'b1);
    if (!abort) begin
      check("data_byte", get_byte(9), rd ? exp_rd : d);
      check("ack2", (bits.size() > 17) ? bits[17] : 1'bx,
            (rd || !acked) ? 1'b1 : 1'b0);
    end
    check("o_valid_busy", ov_seen, 1'b0);
    check("o_valid_done", o_valid, rd);
    if (rd) check("o_data", o_data, exp_rd);
  endtask

  initial begin
    logic       rd;
    logic [6:0] a;
    logic [7:0] d, td;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_ready", i_ready, 1'b0);
    check("rst_scl", scl, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_i_ready", i_ready, 1'b1);
    check("post_rst_scl", scl, 1'b1);
    check("post_rst_sda", sda_level(), 1'b1);
    check("post_rst_o_valid", o_valid, 1'b0);
    check("post_rst_o_data", o_data, 8'h00);

    run_txn(1'b0, 7'h38, 8'h00, 8'h00);
    run_txn(1'b1, 7'h38, 8'h00, 8'hA5);

    repeat (20) @(negedge clk);
    check("hold_o_valid", o_valid, 1'b1);
    check("hold_o_data", o_data, 8'hA5);
    o_ready = 1'b1;
    @(posedge clk);
    #1 o_ready = 1'b0;
    check("o_ready_clear", o_valid, 1'b0);

    run_txn(1'b1, 7'h11, 8'h00, 8'h5A);
    run_txn(1'b1, 7'h38, 8'h00, 8'h3C);
    run_txn(1'b0, 7'h38, 8'hC3, 8'h00);

    for (int k = 0; k < 8; k++) begin
      rd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TGT;
      d  = 8'($urandom);
      td = 8'($urandom);
      run_txn(rd, a, d, td);
    end

    @(negedge clk);
    mode    = WRITE_8BIT_REGISTER;
    i_addr  = TGT;
    i_data  = 8'h81;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (200) @(negedge clk);
    check("mid_busy", i_ready, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_i_ready", i_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_scl", scl, 1'b1);
    check("mid_post_sda", sda_level(), 1'b1);
    check("mid_post_i_ready", i_ready, 1'b1);
    check("mid_post_o_valid", o_valid, 1'b0);

    run_txn(1'b1, 7'h38, 8'h00, 8'h96);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
